key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter N_KEYS, default 4: number of raw keys; 2 to 8.
REQ-002 Parameter TICK_DIV, default 50_000: clk cycles per sample tick (1 ms at 50 MHz).
REQ-003 Parameter DEB_TICKS, default 10: consecutive differing ticks needed to accept a level change.
REQ-004 Parameter LONG_TICKS, default 1000: ticks a key must stay pressed before a long-press event.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-high reset (asserted when 1).
REQ-007 key_in  input  N_KEYS  raw asynchronous keys, low = pressed.
REQ-008 key_level  output  N_KEYS  debounced level per key, low = pressed.
REQ-009 evt_valid  output  1  event available on evt_key/evt_type.
REQ-010 evt_ready  input  1  consumer accepts event when high with evt_valid.
REQ-011 evt_key  output  3  index of key that produced the event.
REQ-012 evt_type  output  2  01 press, 10 release, 11 long press; 00 never valid.
REQ-013 evt_ovf  output  1  one-cycle pulse when an event is dropped.

Function
REQ-014 Each key_in bit SHALL pass a 2-flop synchronizer; all decisions use the synchronized value s[i].
REQ-015 One shared prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is high for the single cycle the count equals TICK_DIV-1.
REQ-016 Per key, a debounce counter SHALL clear in any cycle where s[i]==key_level[i], and increment on tick while s[i]!=key_level[i].
REQ-017 On a tick where s[i]!=key_level[i] and the counter equals DEB_TICKS-1, key_level[i] SHALL toggle next cycle and the counter clear.
REQ-018 A 1->0 key_level transition SHALL generate a press event; 0->1 a release event.
REQ-019 Per key, a hold counter SHALL increment on tick while key_level[i]==0, saturate at LONG_TICKS, and clear when key_level[i]==1.
REQ-020 On the tick where the hold counter reaches LONG_TICKS, exactly one long event SHALL be generated for that press.
REQ-021 Each key SHALL own one pending slot (valid + type); a generated event writes the slot.
REQ-022 If a key's slot is already full and not granted that cycle, the new event SHALL be dropped and evt_ovf pulse for one cycle.
REQ-023 The output register SHALL load when evt_valid==0 or (evt_valid && evt_ready); otherwise evt_valid, evt_key and evt_type SHALL hold stable.
REQ-024 Load selection SHALL be round-robin over full slots, searching from (last granted key + 1) mod N_KEYS; the granted slot is cleared.
REQ-025 If no slot is full at a load opportunity, evt_valid SHALL go 0 (after an accepted event) or stay 0.
REQ-026 Latency: event written to a slot in cycle T SHALL appear with evt_valid=1 in cycle T+1 at earliest.
REQ-027 A grant and a new event for the same key in the same cycle SHALL leave the slot holding the new event, with no overflow.
REQ-028 Multiple keys generating events in one cycle SHALL each fill their own slot; none is lost.
REQ-029 Back-to-back acceptance (evt_ready held 1) SHALL deliver one event per cycle while slots are full.

Reset
REQ-030 While rst_n==1 at a clock edge: key_level all 1, evt_valid 0, evt_key 0, evt_type 0, evt_ovf 0; synchronizers to 1; prescaler, debounce and hold counters 0; slots empty; round-robin pointer so key 0 has first priority.
REQ-031 Reset mid-operation SHALL discard pending and presented events; a key held low through reset SHALL produce a press after the full debounce time.

Verification (TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=8, N_KEYS=4)
REQ-032 Key 0 low steady, evt_ready=1 -> key_level[0]=0 after 3 ticks plus synchronizer delay; one event key=0 type=01.
REQ-033 Key 1 low with a 1-cycle high glitch every 2 ticks -> key_level[1] stays 1, no event.
REQ-034 Key 2 held low 12 ticks then released, evt_ready=1 -> events 01, 11, 10 in order, exactly one 11.
REQ-035 Keys 0-3 pressed simultaneously, evt_ready=0 for 20 cycles then 1 -> evt_valid stable, then keys 0,1,2,3 in successive cycles.
REQ-036 Key 3 press then release with evt_ready=0 throughout -> release dropped, evt_ovf one-cycle pulse, presented press unchanged.
REQ-037 rst_n=1 asserted while evt_valid=1 and slots full -> next cycle all outputs at reset values, no stale event after release.

Source files
------------

// File: rtl/key_event_ctrl.sv
// Debounced key scanner: synchronises raw keys, filters bounce on a shared tick,
// and reports press / release / long-press events through a ready/valid port.
module key_event_ctrl #(
  parameter int N_KEYS     = 4,
  parameter int TICK_DIV   = 50_000,
  parameter int DEB_TICKS  = 10,
  parameter int LONG_TICKS = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2:0]        evt_key,
  output logic [1:0]        evt_type,
  output logic              evt_ovf
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int IW = $clog2(N_KEYS);

  typedef enum logic [1:0] {
    EvNone    = 2'b00,
    EvPress   = 2'b01,
    EvRelease = 2'b10,
    EvLong    = 2'b11
  } evt_type_e;

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [DW-1:0]     deb_q  [N_KEYS];
  logic [DW-1:0]     deb_d  [N_KEYS];
  logic [HW-1:0]     hold_q [N_KEYS];
  logic [HW-1:0]     hold_d [N_KEYS];
  logic [N_KEYS-1:0] gen_v;
  logic [1:0]        gen_t  [N_KEYS];
  logic [N_KEYS-1:0] slot_v_q, slot_v_d;
  logic [1:0]        slot_t_q [N_KEYS];
  logic [1:0]        slot_t_d [N_KEYS];
  logic [N_KEYS-1:0] drop;
  logic [IW-1:0]     last_q, last_d, gnt, cand;
  logic              found, load, gnt_hit;
  logic              valid_q, valid_d;
  logic [2:0]        key_q, key_d;
  logic [1:0]        type_q, type_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    for (int i = 0; i < N_KEYS; i++) begin
      level_d[i] = level_q[i];
      deb_d[i]   = deb_q[i];
      hold_d[i]  = hold_q[i];
      gen_v[i]   = 1'b0;
      gen_t[i]   = EvNone;
      if (sync2_q[i] == level_q[i]) begin
        deb_d[i] = '0;
      end else if (tick) begin
        if (deb_q[i] == DW'(DEB_TICKS - 1)) begin
          deb_d[i]   = '0;
          level_d[i] = ~level_q[i];
          gen_v[i]   = 1'b1;
          gen_t[i]   = level_q[i] ? EvPress : EvRelease;
        end else begin
          deb_d[i] = deb_q[i] + 1'b1;
        end
      end
      // A level edge on the same tick outranks the long-press report.
      if (level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] != HW'(LONG_TICKS)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        if (hold_q[i] == HW'(LONG_TICKS - 1) && !gen_v[i]) begin
          gen_v[i] = 1'b1;
          gen_t[i] = EvLong;
        end
      end
    end
  end

  always_comb begin
    load  = !valid_q || evt_ready;
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      cand = IW'((int'(last_q) + k) % N_KEYS);
      if (!found && slot_v_q[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end

    valid_d = valid_q;
    key_d   = key_q;
    type_d  = type_q;
    last_d  = last_q;
    if (load) begin
      if (found) begin
        valid_d = 1'b1;
        key_d   = 3'(gnt);
        type_d  = slot_t_q[gnt];
        last_d  = gnt;
      end else begin
        valid_d = 1'b0;
      end
    end

    gnt_hit = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      gnt_hit     = load && found && (gnt == IW'(i));
      slot_v_d[i] = slot_v_q[i];
      slot_t_d[i] = slot_t_q[i];
      drop[i]     = 1'b0;
      // A slot freed by this cycle's grant can take the new event directly.
      if (gen_v[i]) begin
        if (slot_v_q[i] && !gnt_hit) begin
          drop[i] = 1'b1;
        end else begin
          slot_v_d[i] = 1'b1;
          slot_t_d[i] = gen_t[i];
        end
      end else if (gnt_hit) begin
        slot_v_d[i] = 1'b0;
      end
    end
    ovf_d = |drop;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      presc_q  <= '0;
      level_q  <= '1;
      slot_v_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        deb_q[i]    <= '0;
        hold_q[i]   <= '0;
        slot_t_q[i] <= '0;
      end
      last_q  <= IW'(N_KEYS - 1);
      valid_q <= 1'b0;
      key_q   <= '0;
      type_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q  <= key_in;
      sync2_q  <= sync1_q;
      presc_q  <= presc_d;
      level_q  <= level_d;
      slot_v_q <= slot_v_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
      slot_t_q <= slot_t_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      key_q    <= key_d;
      type_q   <= type_d;
      ovf_q    <= ovf_d;
    end
  end

  assign key_level = level_q;
  assign evt_valid = valid_q;
  assign evt_key   = key_q;
  assign evt_type  = type_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: expected {key,type} pairs are queued as keys
// are driven and checked in order whenever the DUT hands over an event.
module tb_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic [1:0] evt_type;
  logic       evt_ovf;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [4:0] sbq[$];
  logic [4:0] expItem;
  logic       flagBad;

  key_event_ctrl #(
    .N_KEYS(4), .TICK_DIV(4), .DEB_TICKS(3), .LONG_TICKS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(key_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] keys, input logic ready);
    key_in    = keys;
    evt_ready = ready;
  endtask

  task automatic applyReset();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  task automatic pushExp(input int key, input logic [1:0] typ);
    sbq.push_back({3'(key), typ});
  endtask

  task automatic waitLevel(input int idx, input logic val, input int budget, input string tag);
    int c = 0;
    @(negedge clk);
    while (key_level[idx] !== val && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 32'(key_level[idx]), 32'(val));
  endtask

  task automatic waitValid(input int budget, input string tag);
    int c = 0;
    @(negedge clk);
    while (evt_valid !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 32'(evt_valid), 32'd1);
  endtask

  task automatic waitDrain(input int budget, input string tag);
    int c = 0;
    while (sbq.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput(tag, 32'(sbq.size()), 32'd0);
    step();
  endtask

  // Every accepted handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      checkOutput("event expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        expItem = sbq.pop_front();
        checkOutput("event key/type", 32'({evt_key, evt_type}), 32'(expItem));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    applyStimulus(4'hF, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset key_level", 32'(key_level), 32'hF);
    checkOutput("reset evt_valid", 32'(evt_valid), 32'd0);
    checkOutput("reset evt_key", 32'(evt_key), 32'd0);
    checkOutput("reset evt_type", 32'(evt_type), 32'd0);
    checkOutput("reset evt_ovf", 32'(evt_ovf), 32'd0);

    // Steady press on key 0, then release.
    step();
    pushExp(0, 2'b01);
    applyStimulus(4'b1110, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("key0 not early", 32'(key_level[0]), 32'd1);
    waitLevel(0, 1'b0, 30, "key0 debounced low");
    waitDrain(20, "key0 press drained");
    pushExp(0, 2'b10);
    applyStimulus(4'b1111, 1'b1);
    waitLevel(0, 1'b1, 30, "key0 debounced high");
    waitDrain(20, "key0 release drained");

    // Key 1 glitches high for one cycle every two ticks: never accepted.
    flagBad = 1'b0;
    for (int r = 0; r < 10; r++) begin
      key_in[1] = 1'b0;
      repeat (7) begin
        step();
        if (key_level[1] !== 1'b1 || evt_valid !== 1'b0) flagBad = 1'b1;
      end
      key_in[1] = 1'b1;
      step();
    end
    repeat (20) step();
    checkOutput("glitch rejected", 32'(flagBad), 32'd0);
    checkOutput("glitch level", 32'(key_level), 32'hF);

    // Key 2 held 12 ticks: press, one long, release.
    pushExp(2, 2'b01);
    pushExp(2, 2'b11);
    pushExp(2, 2'b10);
    applyStimulus(4'b1011, 1'b1);
    repeat (48) step();
    applyStimulus(4'b1111, 1'b1);
    waitLevel(2, 1'b1, 40, "key2 released");
    waitDrain(30, "key2 sequence drained");
    repeat (20) step();

    // All keys at once with the consumer stalled, then drained back to back.
    applyStimulus(4'hF, 1'b0);
    applyReset();
    for (int k = 0; k < 4; k++) pushExp(k, 2'b01);
    applyStimulus(4'h0, 1'b0);
    waitValid(40, "multi first valid");
    checkOutput("multi first key", 32'(evt_key), 32'd0);
    flagBad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_key !== 3'd0 || evt_type !== 2'b01) flagBad = 1'b1;
    end
    checkOutput("stalled output stable", 32'(flagBad), 32'd0);
    step();
    evt_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("back-to-back valid", 32'(evt_valid), 32'd1);
    end
    @(negedge clk);
    checkOutput("back-to-back empty", 32'(evt_valid), 32'd0);
    for (int k = 0; k < 4; k++) pushExp(k, 2'b11);
    waitDrain(60, "multi long drained");
    for (int k = 0; k < 4; k++) pushExp(k, 2'b10);
    applyStimulus(4'hF, 1'b1);
    waitDrain(60, "multi release drained");
    repeat (4) step();

    // Key 3: press presented, long waits in the slot, release overflows.
    pushExp(3, 2'b01);
    pushExp(3, 2'b11);
    applyStimulus(4'b0111, 1'b0);
    waitValid(40, "key3 press valid");
    repeat (40) @(negedge clk);
    step();
    key_in[3] = 1'b1;
    begin
      int c = 0;
      @(negedge clk);
      while (evt_ovf !== 1'b1 && c < 60) begin
        @(negedge clk);
        c++;
      end
      checkOutput("ovf pulse seen", 32'(evt_ovf), 32'd1);
    end
    @(negedge clk);
    checkOutput("ovf one cycle", 32'(evt_ovf), 32'd0);
    checkOutput("ovf held valid", 32'(evt_valid), 32'd1);
    checkOutput("ovf held key", 32'(evt_key), 32'd3);
    checkOutput("ovf held type", 32'(evt_type), 32'd1);
    step();
    evt_ready = 1'b1;
    waitDrain(10, "key3 drained");
    repeat (30) @(negedge clk);
    checkOutput("release was dropped", 32'(evt_valid), 32'd0);

    // Reset while an event is presented and another slot is full.
    step();
    applyStimulus(4'b1100, 1'b0);
    waitValid(40, "pre-reset valid");
    repeat (3) @(negedge clk);
    step();
    applyReset();
    @(negedge clk);
    checkOutput("mid reset evt_valid", 32'(evt_valid), 32'd0);
    checkOutput("mid reset evt_key", 32'(evt_key), 32'd0);
    checkOutput("mid reset evt_type", 32'(evt_type), 32'd0);
    checkOutput("mid reset evt_ovf", 32'(evt_ovf), 32'd0);
    checkOutput("mid reset key_level", 32'(key_level), 32'hF);
    flagBad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (evt_valid !== 1'b0) flagBad = 1'b1;
    end
    checkOutput("no stale event", 32'(flagBad), 32'd0);
    pushExp(0, 2'b01);
    pushExp(1, 2'b01);
    step();
    evt_ready = 1'b1;
    waitDrain(40, "post-reset presses");
    pushExp(0, 2'b10);
    pushExp(1, 2'b10);
    applyStimulus(4'hF, 1'b1);
    waitDrain(40, "post-reset releases");
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
